memory_data_selector_pipe: RTL and testbench
============================================

MEMORY_DATA_SELECTOR_PIPE -- requirements
Module: memory_data_selector_pipe

Interface
REQ-001 Parameter WIDTH, default 16: data width in bits; SHALL be even and >= 8.
REQ-002 Parameter NUM_SRC, default 4: number of source channels; SHALL be >= 2.
REQ-003 Parameter SEL_W, default 2: select width; SHALL satisfy 2**SEL_W >= NUM_SRC.
REQ-004 CLK  input  1  sole clock; all state SHALL update on the rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 InValid  input  1  request present on Sel/Mode/Data.
REQ-007 InReady  output  1  block can accept a request this cycle.
REQ-008 Sel  input  SEL_W  source channel index.
REQ-009 Mode  input  2  load mode: 00 word, 01 low byte zero-extend, 10 low byte sign-extend, 11 high byte zero-extend.
REQ-010 Data  input  NUM_SRC*WIDTH  packed sources; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-011 OutValid  output  1  Output/SelErr hold a valid result.
REQ-012 OutReady  input  1  consumer takes the result this cycle.
REQ-013 Output  output  WIDTH  selected and formatted data.
REQ-014 SelErr  output  1  qualifies Output; high when Sel >= NUM_SRC.
REQ-015 ErrCount  output  8  count of accepted requests with a Sel out of range.

Function
REQ-016 The block SHALL hold a 2-entry in-order FIFO of results; occupancy is held in register cnt (0..2).
REQ-017 Accept = InValid & InReady; Emit = OutValid & OutReady.
REQ-018 InReady SHALL equal (cnt != 2), driven from registered state only, with no combinational path from OutReady.
REQ-019 OutValid SHALL equal (cnt != 0); Output/SelErr SHALL present the FIFO head, driven from registers.
REQ-020 Latency: a request accepted at edge k SHALL be visible on Output with OutValid high immediately after edge k when the FIFO was empty.
REQ-021 Formatting SHALL occur at accept time; only formatted results are stored.
REQ-022 Mode 00: Output = channel data.
REQ-023 Mode 01: Output = {zeros, data[7:0]}.
REQ-024 Mode 10: Output = data[7:0] sign-extended from bit 7 to WIDTH.
REQ-025 Mode 11: Output = {zeros, data[15:8]}, with data[WIDTH-1:WIDTH-8] taken when WIDTH != 16.
REQ-026 Sel >= NUM_SRC: the stored result SHALL be all zeros with SelErr=1; otherwise SelErr=0.
REQ-027 Accept without Emit: cnt += 1. Emit without Accept: cnt -= 1.
REQ-028 Accept and Emit in the same cycle: cnt unchanged; the head advances and the new entry is written at the tail.
REQ-029 When cnt==1, simultaneous Accept and Emit SHALL present the new entry as the head after the edge.
REQ-030 cnt==2: InValid is ignored (no accept) and the entries held SHALL remain stable.
REQ-031 cnt==0: OutReady is ignored.
REQ-032 While OutValid=1 and OutReady=0, Output/SelErr SHALL remain stable.
REQ-033 ErrCount SHALL increment on each Accept with Sel >= NUM_SRC and SHALL saturate at 255.
REQ-034 Sel, Mode and Data SHALL be sampled only on Accept; they are don't-care otherwise.

Reset
REQ-035 Reset_n low SHALL immediately force cnt=0, OutValid=0, InReady=1, Output=0, SelErr=0 and ErrCount=0, independent of CLK.
REQ-036 Reset asserted mid-transfer SHALL discard all stored entries; a handshake in progress is not completed.
REQ-037 After Reset_n deasserts, the first Accept SHALL be possible on the first rising edge.

Verification
REQ-038 Use WIDTH=16, NUM_SRC=4. Data ch0..3 = 0x1111, 0x22F3, 0x3380, 0x4444; Sel=1, Mode=00, OutReady=1, one-cycle InValid -> Output=0x22F3 and OutValid=1 for exactly one cycle after the accept edge.
REQ-039 Sel=2 with Mode=01, 10 and 11 in turn -> Output=0x0080, 0xFF80, 0x0033 respectively, each with SelErr=0.
REQ-040 Backpressure: OutReady=0, three consecutive InValid requests with Sel=0,1,3 and Mode=00 -> InReady=0 after 2 accepts, the third is held off; with OutReady=1, the sequence 0x1111, 0x22F3, 0x4444 is emitted in order with no loss or duplication.
REQ-041 cnt==1 with InValid=1 and OutReady=1 held for 10 cycles -> cnt stays 1 and one result is emitted per cycle.
REQ-042 With NUM_SRC=3, Sel=3 -> Output=0x0000, SelErr=1, ErrCount=1; after 300 such requests, ErrCount=255.
REQ-043 Reset_n pulsed low between edges while cnt==2 -> OutValid=0 and InReady=1 before the next edge, and no stale entry appears after release.

Source files
------------

// File: rtl/memory_data_selector_pipe.sv
// Selects one of NUM_SRC packed source channels, formats it by load mode and
// queues the result in a 2-entry in-order FIFO with valid/ready handshakes.
module memory_data_selector_pipe #(
  parameter int WIDTH   = 16,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = 2
) (
  input  logic                       CLK,
  input  logic                       Reset_n,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [SEL_W-1:0]           Sel,
  input  logic [1:0]                 Mode,
  input  logic [NUM_SRC*WIDTH-1:0]   Data,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [WIDTH-1:0]           Output,
  output logic                       SelErr,
  output logic [7:0]                 ErrCount
);

  logic [WIDTH-1:0] chan [NUM_SRC];
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] fmt_data;
  logic             sel_err;

  logic [1:0]       cnt;
  logic [WIDTH-1:0] head_data;
  logic [WIDTH-1:0] tail_data;
  logic             head_err;
  logic             tail_err;
  logic             accept;
  logic             emit;

  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_chan
      assign chan[gi] = Data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign sel_err = (32'(Sel) >= 32'(NUM_SRC));

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (Sel == SEL_W'(i)) sel_data = chan[i];
    end
  end

  // Formatting happens before storage so the FIFO only ever holds final results.
  always_comb begin
    fmt_data = '0;
    case (Mode)
      2'b00:   fmt_data = sel_data;
      2'b01:   fmt_data = {{(WIDTH-8){1'b0}}, sel_data[7:0]};
      2'b10:   fmt_data = {{(WIDTH-8){sel_data[7]}}, sel_data[7:0]};
      default: fmt_data = {{(WIDTH-8){1'b0}}, sel_data[WIDTH-1 -: 8]};
    endcase
    if (sel_err) fmt_data = '0;
  end

  assign InReady  = (cnt != 2'd2);
  assign OutValid = (cnt != 2'd0);
  assign Output   = head_data;
  assign SelErr   = head_err;
  assign accept   = InValid & InReady;
  assign emit     = OutValid & OutReady;

  // The head register always holds the oldest entry; the tail is only used at cnt==2.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt       <= 2'd0;
      head_data <= '0;
      head_err  <= 1'b0;
      tail_data <= '0;
      tail_err  <= 1'b0;
      ErrCount  <= 8'd0;
    end else begin
      if (accept && !emit)      cnt <= cnt + 2'd1;
      else if (emit && !accept) cnt <= cnt - 2'd1;

      if (accept && ((cnt == 2'd0) || ((cnt == 2'd1) && emit))) begin
        head_data <= fmt_data;
        head_err  <= sel_err;
      end else if (emit && (cnt == 2'd2)) begin
        head_data <= tail_data;
        head_err  <= tail_err;
      end

      if (accept && (cnt == 2'd1) && !emit) begin
        tail_data <= fmt_data;
        tail_err  <= sel_err;
      end

      if (accept && sel_err && (ErrCount != 8'hFF)) ErrCount <= ErrCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_memory_data_selector_pipe.sv
// Scoreboard bench: two instances (4 and 3 sources) share stimulus; expected
// results are queued at issue time and popped by a negedge monitor.
module tb_memory_data_selector_pipe;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic        InValid = 1'b0;
  logic        OutReady = 1'b0;
  logic [1:0]  Sel = 2'd0;
  logic [1:0]  Mode = 2'd0;
  logic [63:0] data4 = {16'h4444, 16'h3380, 16'h22F3, 16'h1111};
  logic [47:0] data3;

  logic        in_ready4, out_valid4, sel_err4;
  logic [15:0] output4;
  logic [7:0]  err_count4;
  logic        in_ready3, out_valid3, sel_err3;
  logic [15:0] output3;
  logic [7:0]  err_count3;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0;
  logic [16:0] q4[$];
  logic [16:0] q3[$];
  logic [16:0] e4, e3;

  // {sel, mode, expected data for the 4-source instance}
  logic [19:0] stream [10] = '{
    {2'd1, 2'b01, 16'h00F3}, {2'd1, 2'b10, 16'hFFF3}, {2'd1, 2'b11, 16'h0022},
    {2'd2, 2'b00, 16'h3380}, {2'd3, 2'b01, 16'h0044}, {2'd3, 2'b11, 16'h0044},
    {2'd0, 2'b10, 16'h0011}, {2'd2, 2'b10, 16'hFF80}, {2'd3, 2'b00, 16'h4444},
    {2'd0, 2'b11, 16'h0011}
  };

  assign data3 = data4[47:0];

  memory_data_selector_pipe #(.WIDTH(16), .NUM_SRC(4), .SEL_W(2)) dut4 (
    .CLK(CLK), .Reset_n(Reset_n), .InValid(InValid), .InReady(in_ready4),
    .Sel(Sel), .Mode(Mode), .Data(data4), .OutValid(out_valid4),
    .OutReady(OutReady), .Output(output4), .SelErr(sel_err4), .ErrCount(err_count4)
  );

  memory_data_selector_pipe #(.WIDTH(16), .NUM_SRC(3), .SEL_W(2)) dut3 (
    .CLK(CLK), .Reset_n(Reset_n), .InValid(InValid), .InReady(in_ready3),
    .Sel(Sel), .Mode(Mode), .Data(data3), .OutValid(out_valid3),
    .OutReady(OutReady), .Output(output3), .SelErr(sel_err3), .ErrCount(err_count3)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Holds the request until it is accepted; leaves InValid high on return.
  task automatic send(input logic [1:0] s, input logic [1:0] m, input logic [15:0] exp);
    int waited = 0;
    Sel = s; Mode = m; InValid = 1'b1;
    @(negedge CLK);
    while (!in_ready4 && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    if (!in_ready4) begin
      chk("send_timeout", 32'd0, 32'd1);
    end else begin
      q4.push_back({1'b0, exp});
      q3.push_back((s == 2'd3) ? 17'h10000 : {1'b0, exp});
    end
    @(posedge CLK); #1;
  endtask

  always @(negedge CLK) begin
    if (Reset_n && OutReady) begin
      if (out_valid4) begin
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut4_unexpected got=%h", output4);
        end else begin
          e4 = q4.pop_front();
          $display("emit dut4 data=%h err=%b", output4, sel_err4);
          chk("dut4_result", {15'd0, sel_err4, output4}, {15'd0, e4});
        end
      end
      if (out_valid3) begin
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut3_unexpected got=%h", output3);
        end else begin
          e3 = q3.pop_front();
          $display("emit dut3 data=%h err=%b", output3, sel_err3);
          chk("dut3_result", {15'd0, sel_err3, output3}, {15'd0, e3});
        end
      end
    end
  end

  initial begin
    #3;
    chk("rst_out_valid", out_valid4, 0);
    chk("rst_in_ready", in_ready4, 1);
    chk("rst_output", output4, 0);
    chk("rst_sel_err", sel_err4, 0);
    chk("rst_err_count3", err_count3, 0);
    #9 Reset_n = 1'b1;
    @(posedge CLK); #1;

    // Single word read, valid for exactly one cycle
    OutReady = 1'b1;
    send(2'd1, 2'b00, 16'h22F3);
    InValid = 1'b0;
    chk("single_valid_hi", out_valid4, 1);
    chk("single_head", output4, 16'h22F3);
    @(posedge CLK); #1;
    chk("single_valid_lo", out_valid4, 0);

    // Byte modes on channel 2
    send(2'd2, 2'b01, 16'h0080);
    send(2'd2, 2'b10, 16'hFF80);
    send(2'd2, 2'b11, 16'h0033);
    InValid = 1'b0;
    repeat (3) @(posedge CLK); #1;

    // Backpressure: two fill the FIFO, third is held off
    OutReady = 1'b0;
    send(2'd0, 2'b00, 16'h1111);
    send(2'd1, 2'b00, 16'h22F3);
    Sel = 2'd3; Mode = 2'b00;
    repeat (3) begin
      @(negedge CLK);
      chk("full_in_ready", in_ready4, 0);
      chk("full_hold_head", output4, 16'h1111);
    end
    fork
      begin @(posedge CLK); #1 OutReady = 1'b1; end
    join_none
    send(2'd3, 2'b00, 16'h4444);
    InValid = 1'b0;
    repeat (4) @(posedge CLK); #1;
    chk("err3_after_bp", err_count3, 1);

    // Steady stream at cnt==1: one accept and one emit per cycle
    send(2'd0, 2'b00, 16'h1111);
    c0 = cyc;
    for (int i = 0; i < 10; i++) send(stream[i][19:18], stream[i][17:16], stream[i][15:0]);
    chk("stream_cycles", cyc - c0, 10);
    chk("stream_in_ready", in_ready4, 1);
    chk("stream_out_valid", out_valid4, 1);
    InValid = 1'b0;
    repeat (3) @(posedge CLK); #1;
    chk("err3_after_stream", err_count3, 4);

    // Error counter saturation
    for (int i = 0; i < 300; i++) send(2'd3, 2'b00, 16'h4444);
    InValid = 1'b0;
    repeat (3) @(posedge CLK); #1;
    chk("err3_saturated", err_count3, 255);
    chk("err4_zero", err_count4, 0);

    // Asynchronous reset while full
    OutReady = 1'b0;
    send(2'd0, 2'b00, 16'h1111);
    send(2'd1, 2'b00, 16'h22F3);
    InValid = 1'b0;
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid4, 0);
    chk("arst_in_ready", in_ready4, 1);
    chk("arst_output", output4, 0);
    chk("arst_err_count3", err_count3, 0);
    q4.delete();
    q3.delete();
    Reset_n = 1'b1;
    OutReady = 1'b1;
    c0 = cyc;
    send(2'd2, 2'b00, 16'h3380);
    chk("post_rst_latency", cyc - c0, 1);
    chk("post_rst_valid", out_valid4, 1);
    chk("post_rst_head", output4, 16'h3380);
    InValid = 1'b0;
    repeat (3) @(posedge CLK); #1;
    chk("post_rst_idle", out_valid4, 0);

    for (int i = 0; i < 100 && (q4.size() != 0 || q3.size() != 0); i++) @(posedge CLK);
    #1;
    chk("q4_drained", q4.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
